// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU encodings: add/sub opcode values, status-flag bit
//               positions (also used by the ALU flag register) and a helper
//               that packs the four status flags.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;
    localparam int FLAG_W = 4;

    typedef logic [FLAG_W-1:0] flags_t;

    // Place the individual status bits at their shared register positions.
    function automatic flags_t pack_flags(input logic c, input logic v,
                                          input logic z, input logic n);
        flags_t f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ============================================================================
// Module      : addsub_slice
// Description : Combinational W-bit ripple-carry adder built from a chain of
//               full-adder cells. Besides the carry out it exposes the carry
//               into the slice MSB so the top slice can derive signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_slice
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] w_c;

    assign w_c[0] = cin;

    // One full-adder cell per bit; carry ripples upward through w_c.
    generate
        for (genvar i = 0; i < W; i++) begin : g_fa
            assign s[i]       = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_c[W];
    assign cmsb = w_c[W-1];

endmodule
`default_nettype wire

// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : pipe_addsub
// Description : Pipelined N-bit adder/subtractor. The operands are cut into
//               STAGES slices of W bits; stage k resolves slice k using the
//               carry registered by stage k-1. A single global advance signal
//               stalls every stage at once, giving 1 op/cycle throughput with
//               a fixed latency of STAGES cycles and full backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_addsub
    import alu_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf,
    output logic         zero,
    output logic         neg
);

    localparam int W = N / STAGES;

    // Reject configurations that cannot be split into equal slices.
    generate
        if ((STAGES < 1) || (N % STAGES != 0)) begin : g_bad_cfg
            $error("pipe_addsub: N must be a positive multiple of STAGES");
        end
    endgenerate

    // Stage registers; index k holds the state produced by stage k.
    logic         r_v [STAGES];
    logic         r_c [STAGES];
    logic [N-1:0] r_s [STAGES];
    logic [N-1:0] r_a [STAGES];
    logic [N-1:0] r_b [STAGES];
    flags_t       r_flags;

    // Inputs seen by each stage's slice, and what it will register.
    logic         w_v_cur  [STAGES];
    logic         w_c_cur  [STAGES];
    logic [N-1:0] w_s_cur  [STAGES];
    logic [N-1:0] w_a_cur  [STAGES];
    logic [N-1:0] w_b_cur  [STAGES];
    logic [N-1:0] w_s_next [STAGES];

    logic [N-1:0]      w_slice_s;
    logic [STAGES-1:0] w_slice_cout;
    logic [STAGES-1:0] w_slice_cmsb;
    flags_t            w_flags_next;
    logic              w_advance;

    // The whole pipe moves only when the output register is free or drained.
    assign w_advance = !r_v[STAGES-1] || out_ready;
    assign in_ready  = w_advance;

    // Stage inputs: stage 0 takes the ports (B inverted for subtract), later
    // stages take the skewed operands and carry from the previous register.
    always_comb begin
        w_v_cur[0] = in_valid;
        w_a_cur[0] = a;
        w_b_cur[0] = (sub == OP_SUB) ? ~b : b;
        w_c_cur[0] = (sub == OP_SUB) ? 1'b1 : c_in;
        w_s_cur[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_v_cur[k] = r_v[k-1];
            w_a_cur[k] = r_a[k-1];
            w_b_cur[k] = r_b[k-1];
            w_c_cur[k] = r_c[k-1];
            w_s_cur[k] = r_s[k-1];
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            addsub_slice #(
                .W (W)
            ) u_slice (
                .a    (w_a_cur[k][k*W +: W]),
                .b    (w_b_cur[k][k*W +: W]),
                .cin  (w_c_cur[k]),
                .s    (w_slice_s[k*W +: W]),
                .cout (w_slice_cout[k]),
                .cmsb (w_slice_cmsb[k])
            );
        end
    endgenerate

    // Merge each slice result into the partial sum and derive the final flags
    // from the carries around bit N-1 of the last slice.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_s_next[k]            = w_s_cur[k];
            w_s_next[k][k*W +: W]  = w_slice_s[k*W +: W];
        end
        w_flags_next = pack_flags(w_slice_cout[STAGES-1],
                                  w_slice_cmsb[STAGES-1] ^ w_slice_cout[STAGES-1],
                                  (w_s_next[STAGES-1] == '0),
                                  w_s_next[STAGES-1][N-1]);
    end

    // Stage registers: cleared on reset, all hold together on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_c[k] <= 1'b0;
                r_s[k] <= '0;
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            r_flags <= '0;
        end else if (w_advance) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_v_cur[k];
                r_c[k] <= w_slice_cout[k];
                r_s[k] <= w_s_next[k];
                r_a[k] <= w_a_cur[k];
                r_b[k] <= w_b_cur[k];
            end
            r_flags <= w_flags_next;
        end
    end

    // The last stage's skew/carry registers and the inner-slice MSB carries
    // have no consumer; they exist only to keep the stage logic uniform.
    logic w_unused;
    assign w_unused = ^{r_a[STAGES-1], r_b[STAGES-1], r_c[STAGES-1], w_slice_cmsb};

    assign out_valid = r_v[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign c_out     = r_flags[FLAG_C];
    assign ovf       = r_flags[FLAG_V];
    assign zero      = r_flags[FLAG_Z];
    assign neg       = r_flags[FLAG_N];

endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_addsub
// Description : Self-checking bench for pipe_addsub. Expected results come
//               from a reference add/sub model, are queued at acceptance and
//               compared in order at output transfer, together with latency,
//               hold-while-stalled and reset-flush behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_addsub;

    localparam int N      = 32;
    localparam int STAGES = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;
    logic         neg;

    typedef struct {
        logic [N-1:0] sum;
        logic [3:0]   flags;   // {neg, zero, ovf, c_out}
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    int           checks   = 0;
    int           errors   = 0;
    int           cyc_cnt  = 0;
    int           n_pushed = 0;
    bit           lat_check;
    bit           held_pending;
    logic [N-1:0] held_sum;
    logic [3:0]   held_flags;

    pipe_addsub #(
        .N      (N),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    // Reference model: modulo-2^N add/sub with sign-rule overflow.
    function automatic exp_t model(input logic [N-1:0] ia, input logic [N-1:0] ib,
                                   input logic isub, input logic icin);
        exp_t         m;
        logic [N:0]   full;
        logic [N-1:0] bb;
        logic         cc;
        logic         v;
        bb     = isub ? ~ib : ib;
        cc     = isub ? 1'b1 : icin;
        full   = {1'b0, ia} + {1'b0, bb} + {{N{1'b0}}, cc};
        m.sum  = full[N-1:0];
        v      = (ia[N-1] == bb[N-1]) && (m.sum[N-1] != ia[N-1]);
        m.flags = {m.sum[N-1], (m.sum == '0), v, full[N]};
        m.cyc  = 0;
        return m;
    endfunction

    function automatic logic [N-1:0] rand_op();
        logic [N-1:0] r;
        case ($urandom_range(0, 7))
            0:       r = '0;
            1:       r = '1;
            2:       r = {1'b0, {(N-1){1'b1}}};
            3:       r = {1'b1, {(N-1){1'b0}}};
            default: r = N'({$urandom, $urandom});
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive at the falling edge, then settle and account for the
    // transfers that the next rising edge will perform.
    task automatic cycle(input logic iv, input logic [N-1:0] ia, input logic [N-1:0] ib,
                         input logic isub, input logic icin, input logic ord);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        sub       = isub;
        c_in      = icin;
        out_ready = ord;
        cyc_cnt++;
        #1;
        if (held_pending) begin
            chk("hold_valid", 64'(out_valid), 64'(1'b1));
            chk("hold_sum", 64'(sum), 64'(held_sum));
            chk("hold_flags", 64'({neg, zero, ovf, c_out}), 64'(held_flags));
        end
        held_pending = out_valid && !out_ready;
        held_sum     = sum;
        held_flags   = {neg, zero, ovf, c_out};
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'(1'b0));
            end else begin
                e = exp_q.pop_front();
                chk("sum", 64'(sum), 64'(e.sum));
                chk("flags_nzvc", 64'({neg, zero, ovf, c_out}), 64'(e.flags));
                if (lat_check) chk("latency", 64'(cyc_cnt - e.cyc), 64'(STAGES));
            end
        end
        if (in_valid && in_ready) begin
            e     = model(ia, ib, isub, icin);
            e.cyc = cyc_cnt;
            exp_q.push_back(e);
            n_pushed++;
        end
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (ncyc) @(posedge clk);
        @(negedge clk);
        rst          = 1'b0;
        held_pending = 1'b0;
        exp_q.delete();
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < STAGES + 20 && exp_q.size() > 0; i++)
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic one_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                          input logic isub, input logic icin);
        cycle(1'b1, ia, ib, isub, icin, 1'b1);
        drain();
    endtask

    // Watchdog: a stuck run still reports and stops.
    initial begin
        #200us;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        sub          = 1'b0;
        c_in         = 1'b0;
        out_ready    = 1'b0;
        held_pending = 1'b0;
        lat_check    = 1'b0;

        // Reset state
        do_reset(2);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_flags", 64'({neg, zero, ovf, c_out}), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed add/sub corners with exact latency
        lat_check = 1'b1;
        one_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        one_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        one_op(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
        one_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
        one_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
        one_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        one_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);

        // Back-to-back issue at full throughput
        cycle(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        drain();
        lat_check = 1'b0;

        // Random traffic with random valid and backpressure
        for (int i = 0; i < 6000 && n_pushed < 1000 + 12; i++)
            cycle(1'($urandom_range(0, 1)), rand_op(), rand_op(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        chk("random_ops_issued", 64'(n_pushed >= 1000 + 12), 64'(1));
        drain();

        // Reset flushes in-flight operations
        cycle(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0005, 32'h0000_0006, 1'b1, 1'b0, 1'b0);
        do_reset(1);
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        for (int i = 0; i < STAGES + 6; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            chk("flush_no_ghost", 64'(out_valid), 64'(0));
        end

        // Pipeline still works after the flush
        lat_check = 1'b1;
        one_op(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
